// File: rtl/aibcr3_dcc_pkg.sv
// Shared types and constants for the DCC delay-line controller.
package aibcr3_dcc_pkg;

    localparam int DCC_NCELL  = 64;
    localparam int DCC_CODE_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } dcc_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dcc_dir_t;

    // Thermometer code: cell i is selected when i < code.
    function automatic logic [DCC_NCELL-1:0] dcc_therm(input logic [DCC_CODE_W-1:0] c);
        logic [DCC_NCELL-1:0] t;
        for (int i = 0; i < DCC_NCELL; i++) begin
            t[i] = (DCC_CODE_W'(i) < c);
        end
        return t;
    endfunction

endpackage

// File: rtl/aibcr3_dcc_therm_enc.sv
// Combinational 7-bit delay code to 64-bit thermometer select.
module aibcr3_dcc_therm_enc
    import aibcr3_dcc_pkg::*;
(
    input  logic [DCC_CODE_W-1:0] code,
    output logic [DCC_NCELL-1:0]  therm
);

    always_comb begin
        therm = dcc_therm(code);
    end

endmodule

// File: rtl/aibcr3_dcc_dlyline_ctrl.sv
// DCC delay-line controller: PD sample filter, saturating code stepper, lock FSM.
// Optional code override port pair enabled by defining AIBCR3_DCC_CODE_OVRD_EN.
//
// state  | meaning
// IDLE   | loop disabled or overridden; code held, filter and lock cleared
// TRACK  | stepping the code, counting direction reversals
// LOCKED | dithering about the target; dcc_lock asserted
module aibcr3_dcc_dlyline_ctrl
    import aibcr3_dcc_pkg::*;
#(
    parameter int FILT_LEN  = 8,
    parameter int LOCK_CNT  = 4,
    parameter int INIT_CODE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dcc_en,
    input  logic                  pd_valid,
    input  logic                  pd_up,
    output logic [DCC_NCELL-1:0]  bk,
    output logic [DCC_CODE_W-1:0] code,
    output logic                  dcc_lock,
    output logic                  dcc_sat
`ifdef AIBCR3_DCC_CODE_OVRD_EN
    ,
    input  logic                  ovrd_en,
    input  logic [DCC_CODE_W-1:0] ovrd_code
`endif
);

    localparam int CNT_W = $clog2(FILT_LEN);
    localparam int ACC_W = CNT_W + 1;
    localparam logic [DCC_CODE_W-1:0] CODE_MAX = DCC_CODE_W'(DCC_NCELL);
    localparam logic [DCC_CODE_W-1:0] CODE_RST = DCC_CODE_W'(INIT_CODE);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [ACC_W:0]        ACC_P1   = (ACC_W+1)'(1);
    localparam logic [ACC_W:0]        ACC_M1   = '1;
    localparam logic [3:0]            REV_LOCK = 4'(LOCK_CNT);

    dcc_state_t             state_q, state_d;
    dcc_dir_t               last_q, last_d, dec_dir;
    logic [DCC_CODE_W-1:0]  code_q, code_d;
    logic [DCC_NCELL-1:0]   bk_q, bk_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W:0]         acc_sum;
    logic [3:0]             rev_q, rev_d;
    logic                   sat_q, sat_d;
    logic                   dec_valid;
    logic                   ovrd_act;
    logic [DCC_CODE_W-1:0]  ovrd_val;

`ifdef AIBCR3_DCC_CODE_OVRD_EN
    assign ovrd_act = ovrd_en;
    assign ovrd_val = (ovrd_code > CODE_MAX) ? CODE_MAX : ovrd_code;
`else
    assign ovrd_act = 1'b0;
    assign ovrd_val = CODE_RST;
`endif

    // One guard bit so a full window of same-sign samples cannot wrap.
    assign acc_sum = {acc_q[ACC_W-1], acc_q} + (pd_up ? ACC_P1 : ACC_M1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rev_d     = rev_q;
        sat_d     = sat_q;
        dec_valid = 1'b0;
        dec_dir   = NONE;

        if (!dcc_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            rev_d   = '0;
            last_d  = NONE;
        end else begin
            if (state_q == IDLE) begin
                state_d = TRACK;
            end
            if (pd_valid) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    dec_valid = 1'b1;
                    if (acc_sum == '0) begin
                        dec_dir = NONE;
                    end else if (acc_sum[ACC_W]) begin
                        dec_dir = DN;
                    end else begin
                        dec_dir = UP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = acc_sum[ACC_W-1:0];
                end
            end
        end

        // HOLD and pushes past a limit leave the reversal history alone.
        if (dec_valid) begin
            if (dec_dir == NONE) begin
                sat_d = 1'b0;
            end else if ((dec_dir == UP && code_q == CODE_MAX) ||
                         (dec_dir == DN && code_q == '0)) begin
                sat_d = 1'b1;
            end else begin
                sat_d  = 1'b0;
                code_d = (dec_dir == UP) ? code_q + 7'd1 : code_q - 7'd1;
                last_d = dec_dir;
                if (state_q == LOCKED) begin
                    if (dec_dir == last_q) begin
                        state_d = TRACK;
                        rev_d   = '0;
                    end
                end else if (last_q != NONE && dec_dir != last_q) begin
                    rev_d = rev_q + 4'd1;
                    if (rev_q + 4'd1 == REV_LOCK) begin
                        state_d = LOCKED;
                    end
                end else begin
                    rev_d = '0;
                end
            end
        end

        if (ovrd_act) begin
            state_d = IDLE;
            last_d  = NONE;
            code_d  = ovrd_val;
            cnt_d   = '0;
            acc_d   = '0;
            rev_d   = '0;
            sat_d   = 1'b0;
        end
    end

    aibcr3_dcc_therm_enc u_therm_enc (
        .code  (code_d),
        .therm (bk_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= NONE;
            code_q  <= CODE_RST;
            bk_q    <= dcc_therm(CODE_RST);
            cnt_q   <= '0;
            acc_q   <= '0;
            rev_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            code_q  <= code_d;
            bk_q    <= bk_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rev_q   <= rev_d;
            sat_q   <= sat_d;
        end
    end

    assign bk       = bk_q;
    assign code     = code_q;
    assign dcc_sat  = sat_q;
    assign dcc_lock = (state_q == LOCKED);

endmodule

// File: tb/tb_aibcr3_dcc_dlyline_ctrl.sv
// Self-checking bench for aibcr3_dcc_dlyline_ctrl with a behavioural loop model.
module tb_aibcr3_dcc_dlyline_ctrl;

    localparam int FILT_LEN  = 8;
    localparam int LOCK_CNT  = 4;
    localparam int INIT_CODE = 32;

    logic        clk;
    logic        reset;
    logic        dcc_en;
    logic        pd_valid;
    logic        pd_up;
    logic [63:0] bk;
    logic [6:0]  code;
    logic        dcc_lock;
    logic        dcc_sat;
`ifdef AIBCR3_DCC_CODE_OVRD_EN
    logic        ovrd_en;
    logic [6:0]  ovrd_code;
`endif

    int n_cmp;
    int n_err;

    // model state: code, lock/sat flags, reversal count, last step (+1/-1/0), window
    int m_code, m_lock, m_sat, m_rev, m_last, m_cnt, m_sum;

    aibcr3_dcc_dlyline_ctrl #(
        .FILT_LEN  (FILT_LEN),
        .LOCK_CNT  (LOCK_CNT),
        .INIT_CODE (INIT_CODE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dcc_en   (dcc_en),
        .pd_valid (pd_valid),
        .pd_up    (pd_up),
        .bk       (bk),
        .code     (code),
        .dcc_lock (dcc_lock),
        .dcc_sat  (dcc_sat)
`ifdef AIBCR3_DCC_CODE_OVRD_EN
        ,
        .ovrd_en  (ovrd_en),
        .ovrd_code(ovrd_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_bk(input int c);
        if (c >= 64) return '1;
        return (64'd1 << c) - 64'd1;
    endfunction

    task automatic model_reset();
        m_code = INIT_CODE; m_lock = 0; m_sat = 0;
        m_rev = 0; m_last = 0; m_cnt = 0; m_sum = 0;
    endtask

    task automatic model_edge(input bit en, input bit valid, input bit up);
        int dir;
`ifdef AIBCR3_DCC_CODE_OVRD_EN
        if (ovrd_en) begin
            m_code = (ovrd_code > 7'd64) ? 64 : int'(ovrd_code);
            m_sum = 0; m_cnt = 0; m_lock = 0; m_sat = 0; m_rev = 0; m_last = 0;
            return;
        end
`endif
        if (!en) begin
            m_sum = 0; m_cnt = 0; m_lock = 0; m_rev = 0; m_last = 0;
            return;
        end
        if (!valid) return;
        m_sum += up ? 1 : -1;
        m_cnt++;
        if (m_cnt < FILT_LEN) return;
        dir = (m_sum > 0) ? 1 : ((m_sum < 0) ? -1 : 0);
        m_sum = 0;
        m_cnt = 0;
        if (dir == 0) begin
            m_sat = 0;
            return;
        end
        if (m_code + dir > 64 || m_code + dir < 0) begin
            m_sat = 1;
            return;
        end
        m_code += dir;
        m_sat = 0;
        if (m_lock != 0) begin
            if (dir == m_last) begin
                m_lock = 0;
                m_rev = 0;
            end
        end else if (m_last == -dir) begin
            m_rev++;
            if (m_rev == LOCK_CNT) m_lock = 1;
        end else begin
            m_rev = 0;
        end
        m_last = dir;
    endtask

    task automatic cyc(input bit en, input bit valid, input bit up);
        dcc_en = en; pd_valid = valid; pd_up = up;
        @(posedge clk);
        model_edge(en, valid, up);
        #1;
    endtask

    // FILT_LEN valid samples in random order with random idle gaps
    task automatic window(input int n_up, input int n_dn);
        int u, d;
        bit up;
        u = n_up;
        d = n_dn;
        while (u + d > 0) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if (u == 0) up = 1'b0;
            else if (d == 0) up = 1'b1;
            else up = (int'($urandom_range(1, 32'(u + d))) <= u);
            if (up) u--; else d--;
            cyc(1'b1, 1'b1, up);
        end
    endtask

    task automatic do_reset();
        dcc_en = 1'b0; pd_valid = 1'b0; pd_up = 1'b0;
`ifdef AIBCR3_DCC_CODE_OVRD_EN
        ovrd_en = 1'b0; ovrd_code = 7'd0;
`endif
        #2 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (code !== 7'd32) begin n_err++; $display("FAIL reset_code: got %0d want 32", code); end
        n_cmp++; if (bk !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL reset_bk: got %h want 00000000ffffffff", bk); end
        n_cmp++; if (dcc_lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", dcc_lock); end
        n_cmp++; if (dcc_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", dcc_sat); end
    endtask

    task automatic test_up_step();
        do_reset();
        repeat (FILT_LEN - 1) cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd32) begin n_err++; $display("FAIL up_early: got %0d want 32", code); end
        cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd33) begin n_err++; $display("FAIL up_first: got %0d want 33", code); end
        n_cmp++; if (bk[32] !== 1'b1 || bk !== exp_bk(33)) begin n_err++; $display("FAIL up_bk: got %h want %h", bk, exp_bk(33)); end
        repeat (4) window(FILT_LEN, 0);
        n_cmp++; if (code !== 7'd37 || code !== 7'(m_code)) begin n_err++; $display("FAIL up_five: got %0d want 37 (model %0d)", code, m_code); end
        n_cmp++; if (bk !== exp_bk(37)) begin n_err++; $display("FAIL up_five_bk: got %h want %h", bk, exp_bk(37)); end
    endtask

    task automatic test_lock();
        int exp_code[7] = '{33, 32, 33, 32, 33, 34, 35};
        int exp_lock[7] = '{0, 0, 0, 0, 1, 0, 0};
        do_reset();
        for (int w = 0; w < 7; w++) begin
            if (w >= 5 || w % 2 == 0) window(FILT_LEN, 0);
            else window(0, FILT_LEN);
            n_cmp++;
            if (code !== 7'(exp_code[w]) || dcc_lock !== 1'(exp_lock[w]) || m_lock != exp_lock[w]) begin
                n_err++;
                $display("FAIL lock_win%0d: got code %0d lock %b want code %0d lock %0d", w, code, dcc_lock, exp_code[w], exp_lock[w]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (40) window(FILT_LEN, 0);
        n_cmp++; if (code !== 7'd64 || dcc_sat !== 1'b1) begin n_err++; $display("FAIL sat_reach: got code %0d sat %b want 64 1", code, dcc_sat); end
        window(FILT_LEN, 0);
        n_cmp++; if (code !== 7'd64) begin n_err++; $display("FAIL sat_hold: got %0d want 64", code); end
        n_cmp++; if (bk !== '1) begin n_err++; $display("FAIL sat_bk: got %h want all ones", bk); end
        n_cmp++; if (dcc_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", dcc_sat); end
        window(0, FILT_LEN);
        n_cmp++; if (code !== 7'd63 || dcc_sat !== 1'b0) begin n_err++; $display("FAIL sat_release: got code %0d sat %b want 63 0", code, dcc_sat); end
        n_cmp++; if (bk !== exp_bk(63)) begin n_err++; $display("FAIL sat_release_bk: got %h want %h", bk, exp_bk(63)); end
    endtask

    task automatic test_hold_abort();
        do_reset();
        for (int w = 0; w < 5; w++) begin
            if (w % 2 == 0) window(FILT_LEN, 0); else window(0, FILT_LEN);
        end
        window(FILT_LEN / 2, FILT_LEN / 2);
        n_cmp++; if (code !== 7'd33 || dcc_lock !== 1'b1 || dcc_sat !== 1'b0) begin n_err++; $display("FAIL hold: got code %0d lock %b sat %b want 33 1 0", code, dcc_lock, dcc_sat); end
        window(0, FILT_LEN);
        n_cmp++; if (code !== 7'd32 || dcc_lock !== 1'b1) begin n_err++; $display("FAIL hold_rev: got code %0d lock %b want 32 1", code, dcc_lock); end
        window(0, FILT_LEN);
        n_cmp++; if (code !== 7'd31 || dcc_lock !== 1'b0) begin n_err++; $display("FAIL hold_unlock: got code %0d lock %b want 31 0", code, dcc_lock); end
        repeat (5) cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        repeat (FILT_LEN - 1) cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd31) begin n_err++; $display("FAIL abort_partial: got %0d want 31", code); end
        cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd32 || code !== 7'(m_code)) begin n_err++; $display("FAIL abort_fresh: got %0d want 32", code); end
    endtask

    task automatic test_random();
        int bias;
        bit en, vld, up;
        do_reset();
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 4))
                    0: bias = 95;
                    1: bias = 5;
                    2: bias = 50;
                    3: bias = 60;
                    default: bias = 40;
                endcase
            end
            en  = ($urandom_range(0, 149) != 0);
            vld = ($urandom_range(0, 3) != 0);
            up  = ($urandom_range(0, 99) < bias);
            cyc(en, vld, up);
            n_cmp++; if (code !== 7'(m_code)) begin n_err++; $display("FAIL rand_code @%0d: got %0d want %0d", i, code, m_code); end
            n_cmp++; if (bk !== exp_bk(m_code)) begin n_err++; $display("FAIL rand_bk @%0d: got %h want %h", i, bk, exp_bk(m_code)); end
            n_cmp++; if (dcc_lock !== 1'(m_lock)) begin n_err++; $display("FAIL rand_lock @%0d: got %b want %0d", i, dcc_lock, m_lock); end
            n_cmp++; if (dcc_sat !== 1'(m_sat)) begin n_err++; $display("FAIL rand_sat @%0d: got %b want %0d", i, dcc_sat, m_sat); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int w = 0; w < 5; w++) begin
            if (w % 2 == 0) window(FILT_LEN, 0); else window(0, FILT_LEN);
        end
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (dcc_lock !== 1'b1 || code !== 7'd33) begin n_err++; $display("FAIL areset_pre: got code %0d lock %b want 33 1", code, dcc_lock); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (code !== 7'd32 || bk !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL areset_code: got %0d bk %h want 32", code, bk); end
        n_cmp++; if (dcc_lock !== 1'b0 || dcc_sat !== 1'b0) begin n_err++; $display("FAIL areset_flags: got lock %b sat %b want 0 0", dcc_lock, dcc_sat); end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (FILT_LEN - 3) cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd32) begin n_err++; $display("FAIL areset_window: got %0d want 32", code); end
    endtask

`ifdef AIBCR3_DCC_CODE_OVRD_EN
    task automatic test_override();
        do_reset();
        window(FILT_LEN, 0);
        ovrd_en = 1'b1; ovrd_code = 7'd100;
        cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd64 || bk !== '1) begin n_err++; $display("FAIL ovrd_clamp: got %0d want 64", code); end
        ovrd_code = 7'd10;
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        n_cmp++; if (code !== 7'd10 || bk !== 64'h3FF) begin n_err++; $display("FAIL ovrd_10: got %0d bk %h want 10 3ff", code, bk); end
        n_cmp++; if (dcc_lock !== 1'b0 || dcc_sat !== 1'b0) begin n_err++; $display("FAIL ovrd_flags: got %b %b want 0 0", dcc_lock, dcc_sat); end
        ovrd_en = 1'b0;
        window(FILT_LEN, 0);
        n_cmp++; if (code !== 7'd11 || code !== 7'(m_code)) begin n_err++; $display("FAIL ovrd_resume: got %0d want 11", code); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        dcc_en = 1'b0; pd_valid = 1'b0; pd_up = 1'b0;
`ifdef AIBCR3_DCC_CODE_OVRD_EN
        ovrd_en = 1'b0; ovrd_code = 7'd0;
`endif
        model_reset();
        test_reset();
        test_up_step();
        test_lock();
        test_saturation();
        test_hold_abort();
        test_async_reset();
`ifdef AIBCR3_DCC_CODE_OVRD_EN
        test_override();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
